// File: rtl/audio_i2s_tx_pkg.sv
// rtl/audio_i2s_tx_pkg.sv - shared constants, state type and sample processing for the I2S transmitter
package audio_i2s_tx_pkg;

    localparam int SLOT_BITS   = 16;
    localparam int FRAME_SLOTS = 32;

    // lrclk is high for the slots that precede and carry the right word
    localparam int LR_HIGH_FIRST = SLOT_BITS - 1;
    localparam int LR_HIGH_LAST  = FRAME_SLOTS - 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Volume is an arithmetic right shift; mute overrides it with silence
    function automatic logic [SLOT_BITS-1:0] proc(
        input logic [SLOT_BITS-1:0] x,
        input logic [3:0]           vol,
        input logic                 mute
    );
        logic signed [SLOT_BITS-1:0] shifted;
        shifted = $signed(x) >>> vol;
        return mute ? '0 : shifted;
    endfunction

endpackage

// File: rtl/audio_i2s_tx_clkgen.sv
// rtl/audio_i2s_tx_clkgen.sv - BCLK divider, edge ticks and slot counter
module audio_i2s_clkgen #(
    parameter int HALF_DIV = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       run,
    output logic       bclk,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic [4:0] slot
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          wrap;

    // Ticks are asserted in the clk cycle whose edge will toggle bclk
    assign wrap      = run && (div_cnt == DIV_LAST);
    assign rise_tick = wrap && !bclk;
    assign fall_tick = wrap && bclk;

    // Divider, bit clock and slot counter; held cleared while stopped or starting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= '0;
        end else if (start || !run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            slot    <= '0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                slot <= slot + 5'd1;
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - stereo Philips I2S transmitter with frame-aligned volume and mute
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int HALF_DIV = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        mute,
    input  logic [3:0]  vol,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_dout,
    output logic        frame_strobe,
    output logic        busy
);

    state_t      state;
    logic [31:0] shreg;
    logic [4:0]  slot;
    logic [4:0]  next_slot;
    logic        rise_tick;
    logic        fall_tick;
    logic        start;
    logic        run;
    logic        slot_end;

    assign start     = (state == IDLE) && en;
    assign run       = (state == RUN);
    assign next_slot = slot + 5'd1;
    // A slot ends on the bclk edge that takes bclk from high to low
    assign slot_end  = (rise_tick || fall_tick) && i2s_bclk;
    assign i2s_dout  = shreg[31];

    audio_i2s_clkgen #(
        .HALF_DIV (HALF_DIV)
    ) u_clkgen (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .run       (run),
        .bclk      (i2s_bclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .slot      (slot)
    );

    // Run/idle control, frame loading, shifting and word select on slot boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            i2s_lrclk    <= 1'b0;
            frame_strobe <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    i2s_lrclk <= 1'b0;
                    if (en) begin
                        shreg        <= {proc(in_l, vol, mute), proc(in_r, vol, mute)};
                        frame_strobe <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    if (slot_end) begin
                        if (slot != 5'(FRAME_SLOTS - 1)) begin
                            shreg     <= shreg << 1;
                            i2s_lrclk <= (next_slot >= 5'(LR_HIGH_FIRST)) &&
                                         (next_slot <= 5'(LR_HIGH_LAST));
                        end else if (en) begin
                            shreg        <= {proc(in_l, vol, mute), proc(in_r, vol, mute)};
                            frame_strobe <= 1'b1;
                            i2s_lrclk    <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            shreg     <= '0;
                            i2s_lrclk <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Stereo I2S transmitter directly downstream of the audio filter/DC-blocker stage.
- Consumes the filtered 16-bit signed L/R samples in the hclk domain (16.777 MHz) and serialises them to the external DAC in Philips I2S format.
- Generates BCLK/LRCLK by clock division, applies frame-aligned volume attenuation and mute, and supports a clean start/stop on frame boundaries.

Parameters:
- HALF_DIV, 6, clk cycles per BCLK half-period (minimum 2). Default gives BCLK = 1.398 MHz and fs = 43690 Hz.

Ports:
- clk  in  1  hclk, 16.777 MHz
- reset  in  1  asynchronous, active-high
- en  in  1  run request; start/stop take effect only on frame boundaries
- mute  in  1  forces transmitted samples to 0; sampled at frame load
- vol  in  4  attenuation as arithmetic right shift 0..15; sampled at frame load
- in_l  in  16  signed left sample from the filter stage, same clock domain
- in_r  in  16  signed right sample
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left
- i2s_dout  out  1  serial data; changes on BCLK falling edge, MSB first
- frame_strobe  out  1  one-clk pulse when a new L/R pair is latched
- busy  out  1  high while in RUN

Behaviour:
- Reset (async): state=IDLE; bclk, lrclk, dout, frame_strobe and busy all 0; counters and shift register cleared. Reset mid-frame aborts immediately, with no completion of the frame.
- States: IDLE and RUN.
- Counters:
  - div_cnt counts 0..HALF_DIV-1 and wraps.
  - slot counts 0..31, one slot per BCLK period.
  - Shift register shreg is 32 bits; dout = shreg[31].
- IDLE, en=0: outputs held 0, div_cnt=0.
- IDLE, en=1, on that clk:
  - Load shreg = {proc(in_l), proc(in_r)}.
  - Pulse frame_strobe; set slot=0, div_cnt=0, bclk=0; state goes to RUN.
  - busy rises on the next clk.
- RUN: on each clk with div_cnt==HALF_DIV-1, toggle bclk.
  - bclk 0->1 (rising): no data change.
  - bclk 1->0 (falling): slot end.
    - If slot<31: slot+1 and shreg shifts left by 1.
    - If slot==31 and en=1: reload shreg from current inputs, pulse frame_strobe, slot=0.
    - If slot==31 and en=0: go to IDLE, clearing dout, lrclk and busy on that same edge.
- Slot timing: each slot lasts 2*HALF_DIV clks; a frame lasts 64*HALF_DIV clks (384 at default).
- lrclk is registered and updated only at slot boundaries:
  - 0 during slots 31 and 0..14; 1 during slots 15..30.
  - Each word's MSB therefore follows the lrclk edge by one BCLK.
- Slot data: slots 0..15 carry L bit15..bit0; slots 16..31 carry R bit15..bit0.
- proc(x) = mute ? 0 : (x >>> vol), 16-bit signed arithmetic shift.
  - vol=15 yields 0 or -1 (16'hFFFF).
  - mute and vol are sampled only at load; mid-frame changes affect the next frame only.
- Inputs are sampled only at load. in_l/in_r changes within a frame are not transmitted until the next frame.
- en deasserted mid-frame: the frame always completes all 32 slots.
- en reasserted in the same clk that IDLE is entered: IDLE's en=1 rule applies on the following clk. The gap is one clk with bclk=0.

Decomposition:
- Shared audio package holds:
  - constants SLOT_BITS=16 and FRAME_SLOTS=32;
  - state typedef {IDLE, RUN};
  - the proc() attenuation/mute function.
- One sub-module, audio_i2s_clkgen: divider, bclk, rise/fall tick outputs and slot counter, cleared by a start input.
- Top level holds the FSM, shift register, lrclk and sample processing.

Test Plan:
- HALF_DIV=6, en=1, vol=0, mute=0, in_l=16'hA5C3, in_r=16'h0F0F:
  - dout sampled on bclk rising edges reads A5C3 then 0F0F, MSB first.
  - lrclk=0 for slots 31, 0..14.
  - frame_strobe period is exactly 384 clks; bclk period is 12 clks.
- vol=2, in_l=16'h8000, in_r=16'h4000 -> transmitted L=16'hE000, R=16'h1000. vol=15, in_l=16'h8000 -> 16'hFFFF.
- mute=1 asserted mid-frame -> current frame still carries data; next frame is all zeros; lrclk/bclk keep running.
- en dropped during slot 10 -> slots 11..31 complete; at the slot-31 falling edge bclk=0, lrclk=0, dout=0, busy=0; no further frame_strobe.
- in_l changed from 16'h1234 to 16'h5678 during slot 5 -> current frame sends 1234; next frame sends 5678.
- reset pulsed during slot 20 -> all outputs 0 asynchronously. After release with en=1: frame_strobe on the first clk, busy on the second clk, first bclk rise HALF_DIV clks after load.
